// File: rtl/race_start_judge.sv
// Race start judge: watches the start lights and the racer's launch input,
// classifies each start as a foul, a timeout or a valid reaction, and keeps
// the best reaction time seen since reset.

package race_start_judge_pkg;

  localparam int unsigned TIME_W = 8;

  // Judge phases; encoding 3'd7 is unused and recovers to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_STAGE   = 3'd2,
    ST_RACE    = 3'd3,
    ST_RESULT  = 3'd4,
    ST_FOUL    = 3'd5,
    ST_TIMEOUT = 3'd6
  } state_e;

  // Verdict flags presented to the lights controller.
  typedef struct packed {
    logic done;
    logic foul;
    logic timeout;
    logic valid;
  } flags_t;

  // Terminal states hold a verdict until the track is released.
  function automatic logic is_terminal(state_e s);
    return (s == ST_RESULT) || (s == ST_FOUL) || (s == ST_TIMEOUT);
  endfunction

endpackage

module race_start_judge
  import race_start_judge_pkg::*;
#(
  parameter logic [7:0] MAX_WAIT = 8'd200
) (
  input  logic       CLOCK,
  input  logic       nReset,
  input  logic       RED,
  input  logic       YELLOW,
  input  logic       GREEN,
  input  logic       GO,
  output logic       DONE,
  output logic       FOUL,
  output logic       TIMEOUT,
  output logic       VALID,
  output logic [7:0] REACTION,
  output logic [7:0] BEST
);

  // Counter value sampled on the last RACE edge before a timeout is declared.
  localparam logic [TIME_W-1:0] LAST_CNT = TIME_W'(MAX_WAIT - 8'd1);
  localparam logic [TIME_W-1:0] BEST_RST = '1;

  state_e            state_q, state_d;
  logic [TIME_W-1:0] cnt_q, cnt_d;
  logic [TIME_W-1:0] reaction_q, reaction_d;
  logic [TIME_W-1:0] best_q, best_d;
  flags_t            flags_q, flags_d;

  logic track_clear_c;
  logic race_expired_c;
  logic enter_race_c;
  logic enter_term_c;
  logic launch_c;

  // Track is released only when every light and the launch input are low.
  assign track_clear_c  = ~(RED | YELLOW | GREEN | GO);
  assign race_expired_c = (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge CLOCK or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; GO always outranks the lights once armed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (RED) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (GO)          state_d = ST_FOUL;
        else if (GREEN)  state_d = ST_RACE;
        else if (YELLOW) state_d = ST_STAGE;
      end
      ST_STAGE: begin
        if (GO)         state_d = ST_FOUL;
        else if (GREEN) state_d = ST_RACE;
      end
      ST_RACE: begin
        if (GO)                  state_d = ST_RESULT;
        else if (race_expired_c) state_d = ST_TIMEOUT;
      end
      ST_RESULT, ST_FOUL, ST_TIMEOUT: begin
        if (track_clear_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the counter, the timing registers and the verdict flags.
  always_comb begin
    cnt_d      = cnt_q;
    reaction_d = reaction_q;
    best_d     = best_q;
    flags_d    = '0;

    enter_race_c = (state_d == ST_RACE) && (state_q != ST_RACE);
    enter_term_c = is_terminal(state_d) && !is_terminal(state_q);
    launch_c     = (state_q == ST_RACE) && GO;

    if (enter_race_c) begin
      cnt_d = '0;
    end else if ((state_q == ST_RACE) && (state_d == ST_RACE)) begin
      cnt_d = cnt_q + TIME_W'(1);
    end

    // Reaction is captured only on a launch; BEST only ever shrinks.
    if (launch_c) begin
      reaction_d = cnt_q;
      if (cnt_q < best_q) best_d = cnt_q;
    end

    flags_d.done    = enter_term_c;
    flags_d.foul    = (state_d == ST_FOUL);
    flags_d.timeout = (state_d == ST_TIMEOUT);
    flags_d.valid   = (state_d == ST_RESULT);
  end

  // Output and datapath registers; reset aborts any judgement in progress.
  always_ff @(posedge CLOCK or negedge nReset) begin
    if (!nReset) begin
      cnt_q      <= '0;
      reaction_q <= '0;
      best_q     <= BEST_RST;
      flags_q    <= '0;
    end else begin
      cnt_q      <= cnt_d;
      reaction_q <= reaction_d;
      best_q     <= best_d;
      flags_q    <= flags_d;
    end
  end

  assign DONE     = flags_q.done;
  assign FOUL     = flags_q.foul;
  assign TIMEOUT  = flags_q.timeout;
  assign VALID    = flags_q.valid;
  assign REACTION = reaction_q;
  assign BEST     = best_q;

endmodule

// File: tb/tb_race_start_judge.sv
// Self-checking bench for race_start_judge: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural reference.

module tb_race_start_judge;

  localparam logic [7:0] MAX_WAIT = 8'd200;

  logic       CLOCK  = 1'b0;
  logic       nReset = 1'b1;
  logic       RED    = 1'b0;
  logic       YELLOW = 1'b0;
  logic       GREEN  = 1'b0;
  logic       GO     = 1'b0;
  logic       DONE, FOUL, TIMEOUT, VALID;
  logic [7:0] REACTION, BEST;

  int checks   = 0;
  int failures = 0;

  race_start_judge #(.MAX_WAIT(MAX_WAIT)) dut (
    .CLOCK    (CLOCK),
    .nReset   (nReset),
    .RED      (RED),
    .YELLOW   (YELLOW),
    .GREEN    (GREEN),
    .GO       (GO),
    .DONE     (DONE),
    .FOUL     (FOUL),
    .TIMEOUT  (TIMEOUT),
    .VALID    (VALID),
    .REACTION (REACTION),
    .BEST     (BEST)
  );

  always #5 CLOCK = ~CLOCK;

  // Input nibble order {RED, YELLOW, GREEN, GO}; flag nibble {DONE, FOUL, TIMEOUT, VALID}.
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_R    = 4'b1000;
  localparam logic [3:0] I_Y    = 4'b0100;
  localparam logic [3:0] I_G    = 4'b0010;
  localparam logic [3:0] I_GO   = 4'b0001;

  // ---------------- behavioural reference ----------------
  // Phases: 0 waiting for red, 1 lights up awaiting green, 2 racing, 3 verdict held.
  // Outcome: 1 foul, 2 timeout, 3 valid reaction.
  int         m_phase, m_elapsed, m_outcome;
  bit         m_first;
  logic [7:0] m_reaction, m_best;

  function automatic void m_reset();
    m_phase    = 0;
    m_elapsed  = 0;
    m_outcome  = 0;
    m_first    = 1'b0;
    m_reaction = 8'h00;
    m_best     = 8'hFF;
  endfunction

  function automatic void m_finish(int outcome);
    m_phase   = 3;
    m_outcome = outcome;
    m_first   = 1'b1;
  endfunction

  function automatic void m_step(logic [3:0] in);
    logic r, y, g, go;
    {r, y, g, go} = in;
    m_first = 1'b0;
    case (m_phase)
      0: if (r) m_phase = 1;
      1: begin
        if (go) m_finish(1);
        else if (g) begin
          m_phase   = 2;
          m_elapsed = 0;
        end
      end
      2: begin
        if (go) begin
          m_reaction = 8'(m_elapsed);
          if (m_elapsed < int'(m_best)) m_best = 8'(m_elapsed);
          m_finish(3);
        end else begin
          m_elapsed = m_elapsed + 1;
          if (m_elapsed == int'(MAX_WAIT)) m_finish(2);
        end
      end
      default: if (!(r | y | g | go)) m_phase = 0;
    endcase
  endfunction

  function automatic logic [3:0] m_flags();
    logic held;
    held = (m_phase == 3);
    return {held && m_first, held && (m_outcome == 1),
            held && (m_outcome == 2), held && (m_outcome == 3)};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%02h required=%02h", name, $time, act, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".flags"}, 8'({DONE, FOUL, TIMEOUT, VALID}), 8'(m_flags()));
    chk({tag, ".reaction"}, REACTION, m_reaction);
    chk({tag, ".best"}, BEST, m_best);
  endtask

  task automatic drive(logic [3:0] in);
    {RED, YELLOW, GREEN, GO} = in;
  endtask

  // Drive one edge's inputs from the falling edge, sample at the next falling edge.
  task automatic step(logic [3:0] in);
    drive(in);
    @(posedge CLOCK);
    m_step(in);
    @(negedge CLOCK);
    chk_model("model");
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    drive(I_NONE);
    nReset = 1'b0;
    #1;
    m_reset();
    chk_model("reset");
    @(negedge CLOCK);
    #1 nReset = 1'b1;
  endtask

  // Green then n quiet RACE edges, then launch: reaction should be n.
  task automatic run_valid(int n);
    step(I_R);
    step(I_G);
    repeat (n) step(I_G);
    step(I_G | I_GO);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] in;
    logic [3:0] flg;
    logic [7:0] rea;
    logic [7:0] best;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [3:0] in, logic [3:0] flg, logic [7:0] rea, logic [7:0] best);
    vec_t v;
    v.in   = in;
    v.flg  = flg;
    v.rea  = rea;
    v.best = best;
    tbl.push_back(v);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset with no clock edge involved.
    m_reset();
    #2 nReset = 1'b0;
    #1;
    chk("por.flags", 8'({DONE, FOUL, TIMEOUT, VALID}), 8'h00);
    chk("por.reaction", REACTION, 8'h00);
    chk("por.best", BEST, 8'hFF);
    @(negedge CLOCK);
    #1 nReset = 1'b1;

    // False start during yellow, GO ignored in IDLE.
    add(I_R,          4'b0000, 8'h00, 8'hFF);
    add(I_Y,          4'b0000, 8'h00, 8'hFF);
    add(I_Y | I_GO,   4'b1100, 8'h00, 8'hFF);
    add(I_Y | I_GO,   4'b0100, 8'h00, 8'hFF);
    add(I_GO,         4'b0100, 8'h00, 8'hFF);
    add(I_NONE,       4'b0000, 8'h00, 8'hFF);
    add(I_GO,         4'b0000, 8'h00, 8'hFF);
    // Clean start, launch on the fifth RACE edge; yellow dropping keeps STAGE.
    add(I_R,          4'b0000, 8'h00, 8'hFF);
    add(I_R,          4'b0000, 8'h00, 8'hFF);
    add(I_Y,          4'b0000, 8'h00, 8'hFF);
    add(I_Y,          4'b0000, 8'h00, 8'hFF);
    add(I_NONE,       4'b0000, 8'h00, 8'hFF);
    add(I_G,          4'b0000, 8'h00, 8'hFF);
    add(I_G,          4'b0000, 8'h00, 8'hFF);
    add(I_G,          4'b0000, 8'h00, 8'hFF);
    add(I_G,          4'b0000, 8'h00, 8'hFF);
    add(I_G,          4'b0000, 8'h00, 8'hFF);
    add(I_G | I_GO,   4'b1001, 8'h04, 8'h04);
    add(I_G,          4'b0001, 8'h04, 8'h04);
    add(I_NONE,       4'b0000, 8'h04, 8'h04);
    // GO and GREEN together in STAGE is a foul.
    add(I_R,          4'b0000, 8'h04, 8'h04);
    add(I_Y,          4'b0000, 8'h04, 8'h04);
    add(4'b0111,      4'b1100, 8'h04, 8'h04);
    add(I_NONE,       4'b0000, 8'h04, 8'h04);
    // All lights at once: GREEN outranks YELLOW; launch on the first RACE edge.
    add(4'b1110,      4'b0000, 8'h04, 8'h04);
    add(4'b1110,      4'b0000, 8'h04, 8'h04);
    add(I_GO,         4'b1001, 8'h00, 8'h00);
    add(I_R,          4'b0001, 8'h00, 8'h00);
    add(I_NONE,       4'b0000, 8'h00, 8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d.flags", i), 8'({DONE, FOUL, TIMEOUT, VALID}), 8'(tbl[i].flg));
      chk($sformatf("vec%0d.reaction", i), REACTION, tbl[i].rea);
      chk($sformatf("vec%0d.best", i), BEST, tbl[i].best);
    end

    // Best tracking across runs; verdict held while a light stays on.
    do_reset();
    run_valid(10);
    chk("best10.done", 8'(DONE), 8'h01);
    chk("best10.best", BEST, 8'd10);
    repeat (3) step(I_R);
    chk("hold.valid", 8'(VALID), 8'h01);
    chk("hold.done", 8'(DONE), 8'h00);
    chk("hold.reaction", REACTION, 8'd10);
    step(I_NONE);
    chk("release.valid", 8'(VALID), 8'h00);
    run_valid(7);
    chk("best7.best", BEST, 8'd7);
    step(I_NONE);
    run_valid(9);
    chk("best9.reaction", REACTION, 8'd9);
    chk("best9.best", BEST, 8'd7);
    step(I_NONE);
    run_valid(7);
    chk("bestEq.best", BEST, 8'd7);
    step(I_NONE);

    // Timeout on the MAX_WAIT-th RACE edge.
    step(I_R);
    step(I_G);
    for (int i = 1; i <= int'(MAX_WAIT); i++) begin
      step(I_G);
      if (i == int'(MAX_WAIT) - 1) chk("tmo.early", 8'({DONE, TIMEOUT}), 8'h00);
    end
    chk("tmo.flags", 8'({DONE, FOUL, TIMEOUT, VALID}), 8'b1010);
    step(I_G);
    chk("tmo.hold", 8'({DONE, TIMEOUT}), 8'b01);
    step(I_NONE);
    chk("tmo.release", 8'(TIMEOUT), 8'h00);

    // Launch on the last possible RACE edge still counts.
    step(I_R);
    step(I_G);
    repeat (int'(MAX_WAIT) - 1) step(I_G);
    step(I_GO);
    chk("lastEdge.reaction", REACTION, MAX_WAIT - 8'd1);
    chk("lastEdge.valid", 8'({VALID, TIMEOUT}), 8'b10);
    step(I_NONE);

    // Reset pulsed between edges mid-RACE.
    step(I_R);
    step(I_G);
    repeat (3) step(I_G);
    #2 nReset = 1'b0;
    #1;
    chk("midRst.flags", 8'({DONE, FOUL, TIMEOUT, VALID}), 8'h00);
    chk("midRst.reaction", REACTION, 8'h00);
    chk("midRst.best", BEST, 8'hFF);
    m_reset();
    #1 nReset = 1'b1;
    step(I_G);
    chk("midRst.idle", 8'({DONE, VALID}), 8'h00);
    step(I_R);
    step(I_G);
    step(I_GO);
    chk("restart.reaction", REACTION, 8'h00);
    chk("restart.flags", 8'({DONE, FOUL, TIMEOUT, VALID}), 8'b1001);
    chk("restart.best", BEST, 8'h00);
    step(I_NONE);

    // Randomized run with occasional asynchronous resets.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] in;
      if ($urandom_range(0, 599) == 0) begin
        #2 nReset = 1'b0;
        #1 m_reset();
        chk_model("rndRst");
        #1 nReset = 1'b1;
      end
      in[3] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 3) == 0);
      in[1] = ($urandom_range(0, 2) == 0);
      in[0] = ($urandom_range(0, 11) == 0);
      step(in);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/race_start_judge.md
RACE_START_JUDGE -- requirements
Module: race_start_judge

Interface
REQ-001 Parameter MAX_WAIT, default 8'd200: RACE-state cycle count at which an absent GO is judged a timeout.
REQ-002 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-003 nReset  input  1  reset, asynchronous, active-low.
REQ-004 RED  input  1  race light from the lights controller, same clock domain, sampled on CLOCK rising edge.
REQ-005 YELLOW  input  1  race light, same sampling as RED.
REQ-006 GREEN  input  1  race light, same sampling as RED.
REQ-007 GO  input  1  racer launch input, same clock domain, level-sensitive.
REQ-008 DONE  output  1  one-cycle pulse on entry to any terminal state.
REQ-009 FOUL  output  1  false start flag, held in FOUL state.
REQ-010 TIMEOUT  output  1  no-launch flag, held in TIMEOUT state.
REQ-011 VALID  output  1  valid reaction flag, held in RESULT state.
REQ-012 REACTION  output  8  reaction time in cycles, registered; valid while VALID=1.
REQ-013 BEST  output  8  minimum valid REACTION since reset.

Function
REQ-014 FSM states SHALL be IDLE, ARMED, STAGE, RACE, RESULT, FOUL_S, TIMEOUT_S; all outputs registered.
REQ-015 IDLE: RED=1 -> ARMED; every other input combination -> stay IDLE; GO ignored in IDLE.
REQ-016 ARMED, priority GO > GREEN > YELLOW: GO=1 -> FOUL_S; else GREEN=1 -> RACE; else YELLOW=1 -> STAGE; else stay.
REQ-017 STAGE, priority GO > GREEN: GO=1 -> FOUL_S; else GREEN=1 -> RACE; else stay, including when YELLOW drops.
REQ-018 Entry to RACE SHALL clear the internal 8-bit counter CNT to 0.
REQ-019 RACE, GO=1: REACTION <= CNT, -> RESULT.
REQ-020 RACE, GO=0 and CNT == MAX_WAIT-1: -> TIMEOUT_S.
REQ-021 RACE, GO=0 otherwise: CNT <= CNT+1. GREEN dropping in RACE is ignored.
REQ-022 REACTION SHALL equal the number of rising edges in RACE before the edge that samples GO=1; GO sampled on the first RACE edge gives 0.
REQ-023 Entry to RESULT with REACTION < BEST SHALL set BEST <= REACTION; equal or greater leaves BEST unchanged.
REQ-024 FOUL_S, TIMEOUT_S and RESULT SHALL never modify BEST.
REQ-025 DONE SHALL be 1 exactly on the first cycle in RESULT, FOUL_S or TIMEOUT_S, and 0 otherwise.
REQ-026 Flags in terminal states:
- FOUL=1 only in FOUL_S.
- TIMEOUT=1 only in TIMEOUT_S.
- VALID=1 only in RESULT.
- All three are mutually exclusive.
REQ-027 Any terminal state SHALL hold, with outputs stable, until RED=YELLOW=GREEN=0 and GO=0 on the same edge, then -> IDLE.
REQ-028 REACTION SHALL retain its last value outside RESULT; only VALID qualifies it.
REQ-029 No input combination, including multiple lights high at once, SHALL cause an undefined state; unused encodings -> IDLE.

Reset
REQ-030 nReset=0 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, CNT=0.
- REACTION=8'h00, BEST=8'hFF.
- DONE, FOUL, TIMEOUT, VALID = 0.
REQ-031 Reset asserted mid-RACE or in any other state SHALL abort the judgement with no DONE pulse; BEST reverts to 8'hFF.
REQ-032 First active edge after nReset rises SHALL evaluate IDLE transitions normally.

Verification
REQ-033 Clean start: RED 2 cycles, YELLOW 2 cycles, GREEN, GO high on 5th RACE edge -> DONE pulse, VALID=1, REACTION=4, BEST=4.
REQ-034 False start: GO=1 while YELLOW=1 -> FOUL=1, DONE one pulse, BEST unchanged at 8'hFF.
REQ-035 GO and GREEN sampled on the same edge in STAGE -> FOUL_S, not RACE.
REQ-036 Timeout: GREEN, GO never asserted, MAX_WAIT=200 -> TIMEOUT=1 at the 200th RACE edge, DONE pulse, VALID=0.
REQ-037 Best tracking: valid runs with REACTION 10, then 7, then 9, with lights/GO released between runs -> BEST 10, 7, 7; a terminal state is held while any light stays high.
REQ-038 nReset pulsed low mid-RACE between clock edges -> outputs cleared asynchronously, BEST=8'hFF, no DONE; next RED restarts from ARMED.
